// File: rtl/call_request_latch.sv
// -----------------------------------------------------------------------------
// call_request_latch
//
// Purpose:
//   Turns debounced, active-low floor buttons into latched floor calls.
//   Calls are cleared as the car services each floor. From the pending set,
//   the car position and the travel direction it picks a registered
//   next-target floor for the lift controller.
//
// Build option:
//   CALL_CANCEL_EN - when defined, holding the button of a floor that is
//                    already pending for HOLD_TICKS slowref strobes cancels
//                    that call. When undefined, no hold counters are built,
//                    slowref is ignored, and calls clear only on service.
//
// Parameters:
//   NFLOORS    - number of floors / button lines (2..16)
//   FW         - floor index width, 2**FW >= NFLOORS
//   HOLD_TICKS - slowref strobes of continuous hold that cancel a call
//
// Ports:
//   clk         in   system clock
//   resetb      in   asynchronous active-low reset
//   slowref     in   one-cycle slow reference strobe (cancel timing only)
//   btn_clean   in   debounced buttons, 0 = pressed, 1 = idle
//   cur_floor   in   floor the car is at or passing
//   dir_up      in   travel direction, 1 = up, 0 = down
//   svc_valid   in   one-cycle strobe: svc_floor has been serviced
//   svc_floor   in   floor being serviced (out-of-range values are ignored)
//   pending     out  latched call bits
//   new_req     out  one-cycle pulse when any call newly latches
//   any_pending out  OR of pending, aligned with pending
//   tgt_valid   out  tgt_floor is meaningful
//   tgt_floor   out  selected next target floor
// -----------------------------------------------------------------------------
module call_request_latch #(
    parameter int NFLOORS    = 8,
    parameter int FW         = 3,
    parameter int HOLD_TICKS = 16
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               slowref,
    input  logic [NFLOORS-1:0] btn_clean,
    input  logic [FW-1:0]      cur_floor,
    input  logic               dir_up,
    input  logic               svc_valid,
    input  logic [FW-1:0]      svc_floor,
    output logic [NFLOORS-1:0] pending,
    output logic               new_req,
    output logic               any_pending,
    output logic               tgt_valid,
    output logic [FW-1:0]      tgt_floor
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NFLOORS-1:0] btn_prev_q;
    logic               armed_q;
    logic [NFLOORS-1:0] pending_q,  pending_d;
    logic               new_req_q,  new_req_d;
    logic               any_pending_q;
    logic               tgt_valid_q, tgt_valid_d;
    logic [FW-1:0]      tgt_floor_q, tgt_floor_d;

    logic [NFLOORS-1:0] press;
    logic [NFLOORS-1:0] clr;
    logic [NFLOORS-1:0] cancel;

    // -------------------------------------------------------------------------
    // Press detection and service clears
    // -------------------------------------------------------------------------
    // btn_prev resets to idle (all 1s), so a button still held when reset is
    // released would look like a fresh falling edge. armed_q masks presses for
    // the first clock after reset, which lets btn_prev load the real button
    // levels: a held button only latches again after a release and re-press.
    always_comb begin
        press = armed_q ? (btn_prev_q & ~btn_clean) : '0;
    end

    // svc_floor values >= NFLOORS match no index, so they clear nothing.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default before
        // any conditional update, so no path leaves it unassigned (no latch).
        clr = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            clr[i] = svc_valid && (svc_floor == FW'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Optional press-and-hold cancel
    // -------------------------------------------------------------------------
`ifdef CALL_CANCEL_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    logic [NFLOORS-1:0][HW-1:0] hold_q, hold_d;

    // A counter only runs while its call is pending and its button is held.
    // Once saturated it requests the cancel; the call drops on the next clock.
    always_comb begin
        hold_d = hold_q;
        cancel = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            cancel[i] = (hold_q[i] == HOLD_MAX);
            if (btn_clean[i] || !pending_q[i]) begin
                hold_d[i] = '0;
            end else if (slowref && (hold_q[i] != HOLD_MAX)) begin
                hold_d[i] = hold_q[i] + HW'(1);
            end
        end
    end

    // NOTE: these counters are control state, not storage, so each one is
    // reset; a counter starting from X would cancel calls at random.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    localparam int unused_hold_ticks = HOLD_TICKS;
    logic unused_slowref;

    assign unused_slowref = slowref;
    assign cancel         = '0;
`endif

    // -------------------------------------------------------------------------
    // Pending set and request pulse
    // -------------------------------------------------------------------------
    // A clear or cancel wins over a simultaneous press: the car is already at
    // that floor. Only a press on a floor that ends up newly latched counts
    // as a request; cancels never pulse new_req.
    always_comb begin
        pending_d = (pending_q | press) & ~clr & ~cancel;
        new_req_d = |(press & ~pending_q & ~clr);
    end

    // -------------------------------------------------------------------------
    // Target selection (from the registered pending set)
    // -------------------------------------------------------------------------
    logic          ge_found, gt_found, le_found, lt_found;
    logic [FW-1:0] ge_lo,    gt_lo,    le_hi,    lt_hi;
    logic [FW-1:0] sel_floor;
    int            cur_int;

    always_comb begin
        cur_int  = int'(cur_floor);
        ge_found = 1'b0;
        gt_found = 1'b0;
        le_found = 1'b0;
        lt_found = 1'b0;
        ge_lo    = '0;
        gt_lo    = '0;
        le_hi    = '0;
        lt_hi    = '0;

        // Descending scan: the last hit is the lowest floor above the car.
        for (int i = NFLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (i >= cur_int)) begin
                ge_found = 1'b1;
                ge_lo    = FW'(i);
            end
            if (pending_q[i] && (i > cur_int)) begin
                gt_found = 1'b1;
                gt_lo    = FW'(i);
            end
        end

        // Ascending scan: the last hit is the highest floor below the car.
        // With cur_floor >= NFLOORS every pending floor falls in this group.
        for (int i = 0; i < NFLOORS; i++) begin
            if (pending_q[i] && (i <= cur_int)) begin
                le_found = 1'b1;
                le_hi    = FW'(i);
            end
            if (pending_q[i] && (i < cur_int)) begin
                lt_found = 1'b1;
                lt_hi    = FW'(i);
            end
        end

        // Keep going the current way if anything lies ahead (the current
        // floor counts as ahead); otherwise reverse to the nearest call behind.
        if (dir_up) begin
            sel_floor = ge_found ? ge_lo : lt_hi;
        end else begin
            sel_floor = le_found ? le_hi : gt_lo;
        end

        if (pending_q != '0) begin
            tgt_valid_d = 1'b1;
            tgt_floor_d = sel_floor;
        end else begin
            tgt_valid_d = 1'b0;
            tgt_floor_d = tgt_floor_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            btn_prev_q    <= '1;
            armed_q       <= 1'b0;
            pending_q     <= '0;
            new_req_q     <= 1'b0;
            any_pending_q <= 1'b0;
            tgt_valid_q   <= 1'b0;
            tgt_floor_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, whatever the statement order.
            btn_prev_q    <= btn_clean;
            armed_q       <= 1'b1;
            pending_q     <= pending_d;
            new_req_q     <= new_req_d;
            any_pending_q <= |pending_d;
            tgt_valid_q   <= tgt_valid_d;
            tgt_floor_q   <= tgt_floor_d;
        end
    end

    assign pending     = pending_q;
    assign new_req     = new_req_q;
    assign any_pending = any_pending_q;
    assign tgt_valid   = tgt_valid_q;
    assign tgt_floor   = tgt_floor_q;

    // Cases are
    //   (the comment below is intentionally absent)
endmodule

// File: tb/tb_call_request_latch.sv
// -----------------------------------------------------------------------------
// tb_call_request_latch
//
// Directed bench for call_request_latch (NFLOORS=8, FW=4, HOLD_TICKS=4).
// FW=4 leaves room for out-of-range svc_floor / cur_floor values.
// Each stimulus step pushes its hand-computed post-edge outputs into a
// queue; a separate monitor pops one entry per clock and compares.
// Define CALL_CANCEL_EN for both RTL and bench to cover the cancel feature.
// -----------------------------------------------------------------------------
module tb_call_request_latch;

    localparam int NF = 8;
    localparam int FW = 4;
    localparam int HT = 4;

    logic          clk = 1'b0;
    logic          resetb;
    logic          slowref;
    logic [NF-1:0] btn;
    logic [FW-1:0] cur;
    logic          up;
    logic          sv;
    logic [FW-1:0] sf;

    logic [NF-1:0] pending;
    logic          new_req;
    logic          any_pending;
    logic          tgt_valid;
    logic [FW-1:0] tgt_floor;

    call_request_latch #(
        .NFLOORS   (NF),
        .FW        (FW),
        .HOLD_TICKS(HT)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .slowref    (slowref),
        .btn_clean  (btn),
        .cur_floor  (cur),
        .dir_up     (up),
        .svc_valid  (sv),
        .svc_floor  (sf),
        .pending    (pending),
        .new_req    (new_req),
        .any_pending(any_pending),
        .tgt_valid  (tgt_valid),
        .tgt_floor  (tgt_floor)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NF-1:0] p;
        logic          nr;
        logic          any;
        logic          tv;
        logic [FW-1:0] tf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mon_idx  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Push the expected outputs after the coming edge, then move to the next
    // falling edge where the caller sets up the following inputs.
    task automatic tick(input logic [NF-1:0] p, input logic nr, input logic any,
                        input logic tv, input logic [FW-1:0] tf);
        exp_t e;
        e.p   = p;
        e.nr  = nr;
        e.any = any;
        e.tv  = tv;
        e.tf  = tf;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one expected entry per clock, compared just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("pending@%0d", mon_idx),     32'(pending),     32'(e.p));
                check($sformatf("new_req@%0d", mon_idx),     32'(new_req),     32'(e.nr));
                check($sformatf("any_pending@%0d", mon_idx), 32'(any_pending), 32'(e.any));
                check($sformatf("tgt_valid@%0d", mon_idx),   32'(tgt_valid),   32'(e.tv));
                check($sformatf("tgt_floor@%0d", mon_idx),   32'(tgt_floor),   32'(e.tf));
                mon_idx++;
            end
        end
    end

    initial begin : stimulus
        resetb  = 1'b0;
        slowref = 1'b0;
        btn     = 8'hFF;
        cur     = 4'd0;
        up      = 1'b1;
        sv      = 1'b0;
        sf      = 4'd0;

        repeat (2) @(negedge clk);
        check("reset_pending",     32'(pending),     32'h0);
        check("reset_new_req",     32'(new_req),     32'h0);
        check("reset_any_pending", 32'(any_pending), 32'h0);
        check("reset_tgt_valid",   32'(tgt_valid),   32'h0);
        check("reset_tgt_floor",   32'(tgt_floor),   32'h0);
        resetb = 1'b1;

        // Idle buttons: nothing latches, no requests, no target.
        repeat (10) tick(8'h00, 0, 0, 0, 4'd0);

        // Press floor 5 from floor 2 going up, hold it.
        cur = 4'd2; up = 1'b1;
        btn = 8'hDF; tick(8'h20, 1, 1, 0, 4'd0);
        repeat (49)  tick(8'h20, 0, 1, 1, 4'd5);
        btn = 8'hFF; tick(8'h20, 0, 1, 1, 4'd5);

        // Service floor 5; target goes invalid but holds its value.
        sv = 1'b1; sf = 4'd5; tick(8'h00, 0, 0, 1, 4'd5);
        sv = 1'b0;            tick(8'h00, 0, 0, 0, 4'd5);

        // Floors 1 and 6 pressed together from floor 4: one request pulse.
        cur = 4'd4;
        btn = 8'hBD; tick(8'h42, 1, 1, 0, 4'd5);
        tick(8'h42, 0, 1, 1, 4'd6);
        tick(8'h42, 0, 1, 1, 4'd6);
        up = 1'b0;   tick(8'h42, 0, 1, 1, 4'd1);
        up = 1'b1; sv = 1'b1; sf = 4'd6;
        tick(8'h02, 0, 1, 1, 4'd6);
        sv = 1'b0;   tick(8'h02, 0, 1, 1, 4'd1);   // reversal
        btn = 8'hFF; tick(8'h02, 0, 1, 1, 4'd1);

        // Press and service of floor 3 in the same cycle: clear wins.
        btn = 8'hF7; sv = 1'b1; sf = 4'd3; tick(8'h02, 0, 1, 1, 4'd1);
        sv = 1'b0;   tick(8'h02, 0, 1, 1, 4'd1);
        btn = 8'hFF; tick(8'h02, 0, 1, 1, 4'd1);
        // Out-of-range service floor changes nothing.
        sv = 1'b1; sf = 4'd9; tick(8'h02, 0, 1, 1, 4'd1);
        sv = 1'b0;
        // Re-press of an already pending floor: no request.
        btn = 8'hFD; tick(8'h02, 0, 1, 1, 4'd1);
        btn = 8'hFF; tick(8'h02, 0, 1, 1, 4'd1);

        // Pending {1,3,7}: sweep position and direction.
        btn = 8'h77; tick(8'h8A, 1, 1, 1, 4'd1);
        btn = 8'hFF; tick(8'h8A, 0, 1, 1, 4'd7);
        cur = 4'd3;  tick(8'h8A, 0, 1, 1, 4'd3);    // current floor, up
        up  = 1'b0;  tick(8'h8A, 0, 1, 1, 4'd3);    // current floor, down
        cur = 4'd0;  tick(8'h8A, 0, 1, 1, 4'd1);    // down from bottom: reverse
        up  = 1'b1;  tick(8'h8A, 0, 1, 1, 4'd1);
        cur = 4'd12; tick(8'h8A, 0, 1, 1, 4'd7);    // out of range, up: reverse
        up  = 1'b0;  tick(8'h8A, 0, 1, 1, 4'd7);    // out of range, down
        cur = 4'd6;  tick(8'h8A, 0, 1, 1, 4'd3);
        cur = 4'd8; up = 1'b1; tick(8'h8A, 0, 1, 1, 4'd7);

        // Build pending = 5A with floors 4 and 6 held down.
        sv = 1'b1; sf = 4'd7; tick(8'h0A, 0, 1, 1, 4'd7);
        sv = 1'b0;
        btn = 8'hAF; tick(8'h5A, 1, 1, 1, 4'd3);
        tick(8'h5A, 0, 1, 1, 4'd6);

        // Asynchronous reset between clock edges.
        resetb = 1'b0;
        #1;
        check("async_pending",     32'(pending),     32'h0);
        check("async_new_req",     32'(new_req),     32'h0);
        check("async_any_pending", 32'(any_pending), 32'h0);
        check("async_tgt_valid",   32'(tgt_valid),   32'h0);
        check("async_tgt_floor",   32'(tgt_floor),   32'h0);
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
        // Buttons held through reset must not latch.
        tick(8'h00, 0, 0, 0, 4'd0);
        tick(8'h00, 0, 0, 0, 4'd0);
        btn = 8'hFF; tick(8'h00, 0, 0, 0, 4'd0);
        btn = 8'hEF; tick(8'h10, 1, 1, 0, 4'd0);
        tick(8'h10, 0, 1, 1, 4'd4);
        btn = 8'hFF; tick(8'h10, 0, 1, 1, 4'd4);
        sv = 1'b1; sf = 4'd4; tick(8'h00, 0, 0, 1, 4'd4);
        sv = 1'b0;            tick(8'h00, 0, 0, 0, 4'd4);

        // Press-and-hold of floor 2 from floor 0.
        cur = 4'd0; up = 1'b1;
`ifdef CALL_CANCEL_EN
        btn = 8'hFB; tick(8'h04, 1, 1, 0, 4'd4);
        tick(8'h04, 0, 1, 1, 4'd2);
        repeat (3) begin
            slowref = 1'b1; tick(8'h04, 0, 1, 1, 4'd2);
            slowref = 1'b0; tick(8'h04, 0, 1, 1, 4'd2);
        end
        slowref = 1'b1; tick(8'h04, 0, 1, 1, 4'd2);  // fourth strobe
        slowref = 1'b0; tick(8'h00, 0, 0, 1, 4'd2);  // cancelled, no new_req
        tick(8'h00, 0, 0, 0, 4'd2);
        btn = 8'hFF; tick(8'h00, 0, 0, 0, 4'd2);
        // Released after three strobes: the call stays.
        btn = 8'hFB; tick(8'h04, 1, 1, 0, 4'd2);
        tick(8'h04, 0, 1, 1, 4'd2);
        repeat (3) begin
            slowref = 1'b1; tick(8'h04, 0, 1, 1, 4'd2);
            slowref = 1'b0; tick(8'h04, 0, 1, 1, 4'd2);
        end
        btn = 8'hFF; tick(8'h04, 0, 1, 1, 4'd2);
        repeat (3) begin
            slowref = 1'b1; tick(8'h04, 0, 1, 1, 4'd2);
            slowref = 1'b0; tick(8'h04, 0, 1, 1, 4'd2);
        end
`else
        // Without the cancel feature slowref is ignored: the call stays.
        btn = 8'hFB; tick(8'h04, 1, 1, 0, 4'd4);
        tick(8'h04, 0, 1, 1, 4'd2);
        repeat (6) begin
            slowref = 1'b1; tick(8'h04, 0, 1, 1, 4'd2);
            slowref = 1'b0; tick(8'h04, 0, 1, 1, 4'd2);
        end
        btn = 8'hFF; tick(8'h04, 0, 1, 1, 4'd2);
`endif

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/call_request_latch.md
Name: call_request_latch

Overview:
- Sits directly downstream of the push-button debouncers. It consumes one debounced, active-low, idle-high button line per floor.
- Detects each new press, latches it as a pending floor call, and clears calls as the car services each floor.
- From the pending set, the car position and the travel direction, it produces a registered next-target floor for the lift controller FSM.

Parameters:
- NFLOORS, 8, number of floors and button lines (2..16).
- FW, 3, floor index width; must satisfy 2^FW >= NFLOORS.
- HOLD_TICKS, 16, slowref ticks of continuous hold needed to cancel a call (Optional Feature only).

Ports:
- clk  input  1  system clock.
- resetb  input  1  asynchronous active-low reset.
- slowref  input  1  8-32 Hz one-cycle reference strobe, shared with the debouncers.
- btn_clean  input  NFLOORS  debounced buttons; 0 = pressed, 1 = idle.
- cur_floor  input  FW  floor the car is currently at or passing.
- dir_up  input  1  current travel direction; 1 = up, 0 = down.
- svc_valid  input  1  one-cycle strobe: the car has serviced svc_floor (doors opened).
- svc_floor  input  FW  floor being serviced.
- pending  output  NFLOORS  latched call bits, registered.
- new_req  output  1  one-cycle pulse when any pending bit goes 0->1.
- any_pending  output  1  OR of pending, registered.
- tgt_valid  output  1  tgt_floor is meaningful.
- tgt_floor  output  FW  selected next target floor.

Behaviour:
- Reset (resetb low, asynchronous) sets:
  - btn_prev all 1s, because buttons idle high.
  - pending = 0, new_req = 0, any_pending = 0.
  - tgt_valid = 0, tgt_floor = 0.
- Press detection:
  - btn_prev[i] <= btn_clean[i] every clk.
  - press[i] = btn_prev[i] & ~btn_clean[i], i.e. a falling edge; it is a one-cycle event.
  - A held button produces no further press events.
  - Releasing a button has no effect on pending.
- Pending update, each clk:
  - pending[i] <= (pending[i] | press[i]) & ~clr[i].
  - clr[i] = svc_valid & (svc_floor == i).
- Simultaneous press and service of the same floor in the same cycle: clear wins, pending[i] = 0. The car is already there.
- svc_floor >= NFLOORS is ignored. No bit clears, and no error is flagged.
- A press on a floor that is already pending leaves pending unchanged and generates no new_req.
- new_req <= |(press & ~pending & ~clr). It is a single pulse even when several floors are pressed in the same cycle.
- any_pending <= |pending_next, so it is aligned with pending.
- Target selection is combinational from the registered pending, cur_floor and dir_up, and the result is registered. Priority order:
  1. dir_up=1: lowest pending floor f >= cur_floor. dir_up=0: highest pending floor f <= cur_floor.
  2. If none qualifies, the nearest pending floor in the opposite direction. This is the reversal case.
  3. If pending == 0: tgt_valid <= 0 and tgt_floor holds its last value.
- cur_floor itself qualifies in step 1 if it is pending. A pending current floor is therefore always selected.
- cur_floor >= NFLOORS: treat all pending floors as "below". dir_up then falls to step 2.
- Latency:
  - btn_clean falls at edge n.
  - press is seen at edge n+1, and pending/new_req update at that edge.
  - tgt_floor/tgt_valid update at edge n+2.
  - svc_valid at edge n clears pending at n; the target updates at n+1.
- slowref is unused unless the Optional Feature is compiled in.

Optional Feature:
- Macro: CALL_CANCEL_EN.
- Defined:
  - Each floor has a hold counter (width ceil(log2(HOLD_TICKS+1))). It increments on slowref while btn_clean[i]=0 and pending[i]=1, and saturates at HOLD_TICKS.
  - The counter resets to 0 when the button is released or pending[i]=0.
  - When the counter reaches HOLD_TICKS, pending[i] clears on the following clk, at the same priority as clr.
  - new_req is not pulsed by a cancel.
  - A subsequent fresh press re-latches the call normally.
- Undefined: no counters are instantiated, slowref is ignored, and calls clear only via svc_valid.

Test Plan:
- Reset, then btn_clean=8'hFF for 10 cycles -> pending=0, new_req never 1, tgt_valid=0.
- cur_floor=2, dir_up=1; press floor 5 (btn_clean[5] 1->0, held 50 cycles) -> new_req one pulse at n+1, pending=8'h20 persists, tgt_floor=5, tgt_valid=1 at n+2.
- pending floors 1 and 6, cur_floor=4:
  - dir_up=1 -> tgt_floor=6.
  - Switch to dir_up=0 -> tgt_floor=1.
  - svc_valid with svc_floor=6 -> pending=8'h02, and with dir_up=1 tgt_floor=1 (reversal).
- Press floor 3 and svc_valid with svc_floor=3 in the same cycle -> pending[3]=0, new_req=0. Also svc_floor=7 with NFLOORS=6 -> no change.
- Assert resetb low mid-operation with pending=8'h5A -> all outputs 0 immediately, without waiting for clk. After release, a held button does not re-latch until it is released and pressed again.
- CALL_CANCEL_EN, HOLD_TICKS=4: press floor 2 and hold across 4 slowref strobes -> pending[2] clears with no new_req. Repeat with release after 3 strobes -> pending[2] stays 1.
